// File: rtl/fir_tcdm_rr_arbiter_pkg.sv
// Shared constants and types for the FIR TCDM round-robin arbiter slice.
// Default widths match the MP cluster TCDM port.
package fir_tcdm_rr_arbiter_pkg;

  localparam int FIR_TCDM_AW       = 32;
  localparam int FIR_TCDM_DW       = 32;
  localparam int FIR_ARB_MAX_OUTST = 4;
  localparam int FIR_ARB_N_REQ     = 3;

  // Index width that never collapses to zero bits, so depth/count 1 still works.
  function automatic int arb_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef logic [$clog2(FIR_ARB_N_REQ)-1:0] fir_arb_id_t;

endpackage

// File: rtl/fir_arb_id_fifo.sv
// In-order FIFO of requester IDs for granted-but-unanswered transactions.
// Pushes while full and pops while empty are ignored; push+pop keeps count.
module fir_arb_id_fifo
  import fir_tcdm_rr_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int PW = arb_clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
    end
  end

  // Storage needs no reset: entries are only read behind the count.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fir_tcdm_rr_arbiter.sv
// Round-robin share of one TCDM master port among N_REQ FIR requesters.
// Requests pass through combinationally; responses return via an in-order ID FIFO.
module fir_tcdm_rr_arbiter
  import fir_tcdm_rr_arbiter_pkg::*;
#(
  parameter int N_REQ     = FIR_ARB_N_REQ,
  parameter int MAX_OUTST = FIR_ARB_MAX_OUTST,
  parameter int AW        = FIR_TCDM_AW,
  parameter int DW        = FIR_TCDM_DW
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic [N_REQ-1:0]        in_req,
  output logic [N_REQ-1:0]        in_gnt,
  input  logic [N_REQ*AW-1:0]     in_add,
  input  logic [N_REQ-1:0]        in_wen,
  input  logic [N_REQ*DW/8-1:0]   in_be,
  input  logic [N_REQ*DW-1:0]     in_data,
  output logic [DW-1:0]           in_r_data,
  output logic [N_REQ-1:0]        in_r_valid,
  output logic                    out_req,
  input  logic                    out_gnt,
  output logic [AW-1:0]           out_add,
  output logic                    out_wen,
  output logic [DW/8-1:0]         out_be,
  output logic [DW-1:0]           out_data,
  input  logic [DW-1:0]           out_r_data,
  input  logic                    out_r_valid,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int IW = arb_clog2(N_REQ);
  localparam int BW = DW / 8;

  logic [IW-1:0] rr_ptr_q;
  logic [IW-1:0] lock_idx_q;
  logic          lock_q;
  logic          err_q;
  logic [IW-1:0] rr_winner;
  logic [IW-1:0] winner;
  logic [IW-1:0] head_id;
  logic          fifo_full;
  logic          fifo_empty;
  logic          req_ok;
  logic          handshake;

  // First asserted request at or after the round-robin pointer.
  always_comb begin
    int  idx;
    logic found;
    rr_winner = '0;
    found     = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(rr_ptr_q) + i) % N_REQ;
      if (!found && in_req[idx]) begin
        rr_winner = IW'(idx);
        found     = 1'b1;
      end
    end
  end

  // A stalled request keeps its slot until the master accepts it.
  assign winner    = lock_q ? lock_idx_q : rr_winner;
  assign req_ok    = (|in_req) && !fifo_full && !rst_i;
  assign handshake = req_ok && out_gnt;

  always_comb begin
    out_req    = req_ok;
    out_add    = '0;
    out_wen    = 1'b0;
    out_be     = '0;
    out_data   = '0;
    in_gnt     = '0;
    in_r_valid = '0;
    if (req_ok) begin
      out_add  = in_add[winner*AW +: AW];
      out_wen  = in_wen[winner];
      out_be   = in_be[winner*BW +: BW];
      out_data = in_data[winner*DW +: DW];
    end
    if (handshake) in_gnt[winner] = 1'b1;
    if (!rst_i && out_r_valid && !fifo_empty) in_r_valid[head_id] = 1'b1;
  end

  assign in_r_data = rst_i ? '0 : out_r_data;
  assign busy_o    = !rst_i && (!fifo_empty || req_ok);
  assign err_o     = err_q && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (handshake) begin
        rr_ptr_q <= (winner == IW'(N_REQ - 1)) ? '0 : winner + 1'b1;
        lock_q   <= 1'b0;
      end else if (req_ok) begin
        lock_q     <= 1'b1;
        lock_idx_q <= winner;
      end
      if (out_r_valid && fifo_empty) err_q <= 1'b1;
    end
  end

  fir_arb_id_fifo #(
    .DEPTH (MAX_OUTST),
    .W     (IW)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .push    (handshake),
    .wdata   (winner),
    .pop     (out_r_valid),
    .rdata   (head_id),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_fir_tcdm_rr_arbiter.sv
// Bench for fir_tcdm_rr_arbiter: directed scenarios plus a randomized run
// against a queue-based model of grants and outstanding responses.
module tb_fir_tcdm_rr_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MO = 4;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst_i, clear_i;
  logic [N-1:0]      in_req, in_gnt, in_wen, in_r_valid;
  logic [N*AW-1:0]   in_add;
  logic [N*BW-1:0]   in_be;
  logic [N*DW-1:0]   in_data;
  logic [DW-1:0]     in_r_data;
  logic              out_req, out_gnt, out_wen, out_r_valid, busy_o, err_o;
  logic [AW-1:0]     out_add;
  logic [BW-1:0]     out_be;
  logic [DW-1:0]     out_data, out_r_data;

  int errors = 0;
  int checks = 0;

  // Reference model: pointer, stalled owner, queue of outstanding IDs, error flag.
  int              m_ptr;
  bit              m_lock;
  int              m_lock_idx;
  bit              m_err;
  logic [IW-1:0]   exp_q[$];
  int              e_win;
  logic            e_out_req, e_busy, e_err, e_wen;
  logic [N-1:0]    e_gnt, e_rvalid;
  logic [AW-1:0]   e_add;
  logic [BW-1:0]   e_be;
  logic [DW-1:0]   e_data, e_rdata;

  always #5 clk = ~clk;

  fir_tcdm_rr_arbiter dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i),
    .in_req(in_req), .in_gnt(in_gnt), .in_add(in_add), .in_wen(in_wen),
    .in_be(in_be), .in_data(in_data), .in_r_data(in_r_data), .in_r_valid(in_r_valid),
    .out_req(out_req), .out_gnt(out_gnt), .out_add(out_add), .out_wen(out_wen),
    .out_be(out_be), .out_data(out_data), .out_r_data(out_r_data),
    .out_r_valid(out_r_valid), .busy_o(busy_o), .err_o(err_o)
  );

  task automatic model_eval();
    e_out_req = (|in_req) && (exp_q.size() < MO) && !rst_i;
    e_win = 0;
    if (m_lock) e_win = m_lock_idx;
    else for (int i = N - 1; i >= 0; i--) if (in_req[(m_ptr + i) % N]) e_win = (m_ptr + i) % N;
    e_gnt = '0;
    if (e_out_req && out_gnt) e_gnt[e_win] = 1'b1;
    e_add  = e_out_req ? in_add[e_win*AW +: AW] : '0;
    e_wen  = e_out_req ? in_wen[e_win] : 1'b0;
    e_be   = e_out_req ? in_be[e_win*BW +: BW] : '0;
    e_data = e_out_req ? in_data[e_win*DW +: DW] : '0;
    e_rvalid = '0;
    if (!rst_i && out_r_valid && exp_q.size() > 0) e_rvalid[exp_q[0]] = 1'b1;
    e_rdata = rst_i ? '0 : out_r_data;
    e_busy  = !rst_i && (exp_q.size() > 0 || e_out_req);
    e_err   = !rst_i && m_err;
  endtask

  task automatic model_commit();
    if (rst_i || clear_i) begin
      m_ptr = 0; m_lock = 0; m_lock_idx = 0; m_err = 0; exp_q.delete();
    end else begin
      if (out_r_valid) begin
        if (exp_q.size() == 0) m_err = 1;
        else void'(exp_q.pop_front());
      end
      if (e_out_req && out_gnt) begin
        exp_q.push_back(IW'(e_win)); m_ptr = (e_win + 1) % N; m_lock = 0;
      end else if (e_out_req) begin
        m_lock = 1; m_lock_idx = e_win;
      end
    end
  endtask

  // Advance one clock: model follows the edge, then return to the falling edge.
  task automatic tick();
    model_eval();
    model_commit();
    @(negedge clk);
  endtask

  task automatic new_payload(input int i);
    in_add[i*AW +: AW]  = 32'h1000_0000 * (i + 1) + 32'($urandom_range(0, 1023)) * 4;
    in_wen[i]           = 1'($urandom_range(0, 1));
    in_be[i*BW +: BW]   = 4'($urandom_range(1, 15));
    in_data[i*DW +: DW] = $urandom;
  endtask

  task automatic do_reset();
    rst_i = 1; clear_i = 0; in_req = '0; out_gnt = 0; out_r_valid = 0; out_r_data = '0;
    tick();
    rst_i = 0;
  endtask

  task automatic drain();
    int guard = 0;
    in_req = '0; out_gnt = 0;
    while (exp_q.size() > 0 && guard < 16) begin
      out_r_valid = 1; tick(); guard++;
    end
    out_r_valid = 0;
  endtask

  task automatic test_reset();
    rst_i = 1; clear_i = 0; in_req = '1; out_gnt = 1; out_r_valid = 1; out_r_data = 32'hDEAD_BEEF;
    for (int i = 0; i < N; i++) new_payload(i);
    #1;
    checks++; if (out_req !== 1'b0) begin errors++; $display("FAIL rst_out_req: got %b want 0", out_req); end
    checks++; if (in_gnt !== 3'b000) begin errors++; $display("FAIL rst_in_gnt: got %b want 000", in_gnt); end
    checks++; if (in_r_valid !== 3'b000) begin errors++; $display("FAIL rst_in_r_valid: got %b want 000", in_r_valid); end
    checks++; if (in_r_data !== 32'h0) begin errors++; $display("FAIL rst_in_r_data: got %h want 0", in_r_data); end
    checks++; if (out_add !== 32'h0) begin errors++; $display("FAIL rst_out_add: got %h want 0", out_add); end
    checks++; if (busy_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL rst_busy_err: got %b%b want 00", busy_o, err_o); end
    tick();
    rst_i = 0; in_req = '0; out_gnt = 0; out_r_valid = 0;
    #1;
    checks++; if (busy_o !== 1'b0 || err_o !== 1'b0 || out_req !== 1'b0) begin errors++; $display("FAIL post_rst_idle: busy %b err %b req %b want 000", busy_o, err_o, out_req); end
    tick();
  endtask

  task automatic test_fairness();
    logic [N-1:0] prev, want;
    do_reset();
    in_req = '1; out_gnt = 1; prev = '0;
    for (int k = 0; k < 7; k++) begin
      out_r_valid = (prev != '0); out_r_data = 32'hA5A5_0000 + 32'(k);
      if (k == 6) in_req = '0;
      want = (k < 6) ? N'(3'b001 << (k % 3)) : '0;
      #1;
      checks++; if (in_gnt !== want) begin errors++; $display("FAIL fair_gnt k%0d: got %b want %b", k, in_gnt, want); end
      checks++; if (in_r_valid !== prev) begin errors++; $display("FAIL fair_rvalid k%0d: got %b want %b", k, in_r_valid, prev); end
      prev = want;
      tick();
    end
    out_r_valid = 0;
  endtask

  task automatic test_lock_stall();
    logic [AW-1:0] a0, a1;
    do_reset();
    for (int i = 0; i < N; i++) new_payload(i);
    a0 = in_add[0 +: AW]; a1 = in_add[AW +: AW];
    in_req = 3'b010;
    for (int c = 1; c <= 5; c++) begin
      if (c == 2) in_req[0] = 1'b1;
      if (c == 5) in_req[1] = 1'b0;
      out_gnt = (c >= 4);
      #1;
      if (c <= 3) begin
        checks++; if (out_req !== 1'b1 || in_gnt !== 3'b000) begin errors++; $display("FAIL lock_stall c%0d: req %b gnt %b want 1 000", c, out_req, in_gnt); end
        checks++; if (out_add !== a1) begin errors++; $display("FAIL lock_add c%0d: got %h want %h", c, out_add, a1); end
      end else if (c == 4) begin
        checks++; if (in_gnt !== 3'b010 || out_add !== a1) begin errors++; $display("FAIL lock_grant1: gnt %b add %h want 010 %h", in_gnt, out_add, a1); end
      end else begin
        checks++; if (in_gnt !== 3'b001 || out_add !== a0) begin errors++; $display("FAIL lock_grant0: gnt %b add %h want 001 %h", in_gnt, out_add, a0); end
      end
      tick();
    end
    drain();
  endtask

  task automatic test_full();
    do_reset();
    in_req = '1; out_gnt = 1;
    for (int c = 1; c <= 7; c++) begin
      out_r_valid = (c == 6); out_r_data = 32'h0F0F_0006;
      #1;
      if (c <= 4) begin
        checks++; if (out_req !== 1'b1 || in_gnt !== N'(3'b001 << ((c - 1) % 3))) begin errors++; $display("FAIL full_fill c%0d: req %b gnt %b", c, out_req, in_gnt); end
      end else if (c == 5) begin
        checks++; if (out_req !== 1'b0 || in_gnt !== 3'b000 || busy_o !== 1'b1) begin errors++; $display("FAIL full_block: req %b gnt %b busy %b want 0 000 1", out_req, in_gnt, busy_o); end
      end else if (c == 6) begin
        checks++; if (out_req !== 1'b0) begin errors++; $display("FAIL full_no_bypass: got %b want 0", out_req); end
        checks++; if (in_r_valid !== 3'b001 || in_r_data !== 32'h0F0F_0006) begin errors++; $display("FAIL full_route: got %b %h want 001 0f0f0006", in_r_valid, in_r_data); end
      end else begin
        checks++; if (out_req !== 1'b1 || in_gnt !== 3'b010) begin errors++; $display("FAIL full_resume: req %b gnt %b want 1 010", out_req, in_gnt); end
      end
      tick();
    end
    drain();
  endtask

  task automatic test_latency();
    do_reset();
    out_gnt = 1;
    for (int c = 1; c <= 8; c++) begin
      in_req = (c == 1 || c == 3) ? 3'b100 : (c == 2) ? 3'b001 : 3'b000;
      out_r_valid = (c == 5 || c == 7 || c == 8);
      out_r_data = (c == 5) ? 32'hA5A5_0002 : (c == 7) ? 32'hA5A5_0000 : 32'hA5A5_0012;
      #1;
      if (c == 1 || c == 3) begin
        checks++; if (in_gnt !== 3'b100) begin errors++; $display("FAIL lat_gnt c%0d: got %b want 100", c, in_gnt); end
      end else if (c == 2) begin
        checks++; if (in_gnt !== 3'b001) begin errors++; $display("FAIL lat_gnt c2: got %b want 001", in_gnt); end
      end else if (c == 5 || c == 8) begin
        checks++; if (in_r_valid !== 3'b100 || in_r_data !== out_r_data) begin errors++; $display("FAIL lat_resp c%0d: got %b %h want 100 %h", c, in_r_valid, in_r_data, out_r_data); end
      end else if (c == 7) begin
        checks++; if (in_r_valid !== 3'b001 || in_r_data !== 32'hA5A5_0000) begin errors++; $display("FAIL lat_resp c7: got %b %h want 001 a5a50000", in_r_valid, in_r_data); end
      end else begin
        checks++; if (in_r_valid !== 3'b000) begin errors++; $display("FAIL lat_idle c%0d: got %b want 000", c, in_r_valid); end
      end
      tick();
    end
    out_r_valid = 0;
  endtask

  task automatic test_spurious();
    do_reset();
    out_r_valid = 1; out_r_data = 32'h1234_5678;
    #1;
    checks++; if (in_r_valid !== 3'b000 || err_o !== 1'b0) begin errors++; $display("FAIL spur_first: rvalid %b err %b want 000 0", in_r_valid, err_o); end
    tick();
    out_r_valid = 0;
    #1;
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL spur_err_set: got %b want 1", err_o); end
    tick();
    clear_i = 1;
    #1;
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL spur_err_sticky: got %b want 1", err_o); end
    tick();
    clear_i = 0;
    #1;
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL spur_err_clear: got %b want 0", err_o); end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_req = '1; out_gnt = 1;
    tick(); tick();
    in_req = '0; rst_i = 1;
    #1;
    checks++; if (busy_o !== 1'b0 || out_req !== 1'b0) begin errors++; $display("FAIL mid_rst_outputs: busy %b req %b want 0 0", busy_o, out_req); end
    tick();
    rst_i = 0;
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", busy_o); end
    for (int k = 0; k < 2; k++) begin
      out_r_valid = 1; out_r_data = 32'hBAD0_0000 + 32'(k);
      #1;
      checks++; if (in_r_valid !== 3'b000) begin errors++; $display("FAIL mid_late_rvalid %0d: got %b want 000", k, in_r_valid); end
      tick();
    end
    out_r_valid = 0; in_req = '1;
    #1;
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL mid_late_err: got %b want 1", err_o); end
    checks++; if (in_gnt !== 3'b001) begin errors++; $display("FAIL mid_ptr_restart: got %b want 001", in_gnt); end
    tick();
    drain();
  endtask

  task automatic test_random();
    logic [N-1:0] last_gnt;
    do_reset();
    last_gnt = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_req = in_req & ~last_gnt;
      for (int i = 0; i < N; i++)
        if (!in_req[i] && $urandom_range(0, 1) == 1) begin new_payload(i); in_req[i] = 1'b1; end
      clear_i     = ($urandom_range(0, 99) == 0);
      out_gnt     = ($urandom_range(0, 3) != 0);
      out_r_valid = (exp_q.size() > 0) && ($urandom_range(0, 1) == 1);
      out_r_data  = $urandom;
      model_eval();
      #1;
      checks++; if (in_gnt !== e_gnt || out_req !== e_out_req) begin errors++; $display("FAIL rnd_grant cyc%0d: gnt %b req %b want %b %b", cyc, in_gnt, out_req, e_gnt, e_out_req); end
      checks++; if (out_add !== e_add || out_wen !== e_wen || out_be !== e_be || out_data !== e_data) begin errors++; $display("FAIL rnd_mux cyc%0d: %h %b %h %h want %h %b %h %h", cyc, out_add, out_wen, out_be, out_data, e_add, e_wen, e_be, e_data); end
      checks++; if (in_r_valid !== e_rvalid || in_r_data !== e_rdata) begin errors++; $display("FAIL rnd_resp cyc%0d: %b %h want %b %h", cyc, in_r_valid, in_r_data, e_rvalid, e_rdata); end
      checks++; if (busy_o !== e_busy || err_o !== e_err) begin errors++; $display("FAIL rnd_status cyc%0d: busy %b err %b want %b %b", cyc, busy_o, err_o, e_busy, e_err); end
      last_gnt = e_gnt;
      tick();
    end
    clear_i = 0;
    drain();
  endtask

  initial begin
    m_ptr = 0; m_lock = 0; m_lock_idx = 0; m_err = 0;
    in_add = '0; in_wen = '0; in_be = '0; in_data = '0;
    test_reset();
    test_fairness();
    test_lock_stall();
    test_full();
    test_latency();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fir_tcdm_rr_arbiter.md
Name: fir_tcdm_rr_arbiter

Overview:
Shares one TCDM master port between N_REQ FIR-side TCDM requesters, for example the streamer source, the sink and the coefficient loader, using round-robin arbitration. Requests pass through combinationally. Each response is routed back to its originator through an in-order ID FIFO, which allows up to MAX_OUTST outstanding transactions. The block sits between the FIR datapath streamers and one of the MP cluster TCDM ports.

Parameters:
N_REQ, 3, number of requesters (2..8)
MAX_OUTST, 4, maximum granted-but-unanswered transactions (power of 2, at least 1)
AW, 32, address width
DW, 32, data width (byte enable is DW/8)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
clear_i  in  1  synchronous soft clear: same effect as rst_i on internal state
in_req  in  N_REQ  requester request
in_gnt  out  N_REQ  requester grant, one-hot or zero
in_add  in  N_REQ*AW  requester address
in_wen  in  N_REQ  1 = read, 0 = write
in_be  in  N_REQ*DW/8  byte enables
in_data  in  N_REQ*DW  write data
in_r_data  out  DW  response data, broadcast to all requesters
in_r_valid  out  N_REQ  response valid, one-hot or zero
out_req  out  1  master request
out_gnt  in  1  master grant
out_add  out  AW  master address
out_wen  out  1  master write enable
out_be  out  DW/8  master byte enables
out_data  out  DW  master write data
out_r_data  in  DW  master response data
out_r_valid  in  1  master response valid
busy_o  out  1  high when the ID FIFO is non-empty or out_req is high
err_o  out  1  sticky flag: response received with no transaction outstanding

Behaviour:
- Protocol: every granted transaction, read or write, returns exactly one out_r_valid, in order, at least 1 cycle after its grant.
- Handshake: a transaction transfers when out_req && out_gnt. A requester holds req, add, wen, be and data stable until it sees in_gnt.
- Winner selection (combinational):
  - If lock_q is set, the winner is lock_idx_q.
  - Otherwise the winner is the first asserted in_req scanning rr_ptr_q, rr_ptr_q+1, … modulo N_REQ.
- Master signals: out_req = (any in_req) && !fifo_full. out_add, out_wen, out_be and out_data are muxed from the winner, and are all-zero when out_req is 0.
- Requester grant: in_gnt[winner] = out_gnt && out_req. All other bits of in_gnt are 0.
- Lock:
  - Set when out_req && !out_gnt, with lock_idx_q = winner.
  - Cleared on the cycle the master grants.
  - Ensures a stalled request is never re-arbitrated away from its requester.
- Pointer: on a handshake, rr_ptr_q <= (winner+1) mod N_REQ. Otherwise rr_ptr_q holds.
- ID FIFO (depth MAX_OUTST, width clog2(N_REQ)):
  - Push winner on handshake.
  - Pop on out_r_valid.
  - Simultaneous push and pop: count unchanged, pointers both advance.
- Full: while count == MAX_OUTST, out_req = 0. There is no bypass through a same-cycle pop; the grant resumes the following cycle.
- Response routing: in_r_valid[head] = out_r_valid && !fifo_empty. in_r_data = out_r_data always.
- Empty response: if out_r_valid arrives while the FIFO is empty, in_r_valid stays all-zero, err_o is set and stays set until reset or clear.
- Reset/clear (rst_i or clear_i high at a clock edge):
  - rr_ptr_q = 0, lock_q = 0, FIFO count and pointers = 0, err_o = 0.
  - All outputs are forced to 0 during the cycles rst_i is high.
  - Responses outstanding at reset are dropped; any later response sets err_o.
- Latency: zero-cycle request path. Response path is zero cycles from out_r_valid to in_r_valid.

Decomposition:
- fir_package: constants FIR_TCDM_AW = 32, FIR_TCDM_DW = 32, FIR_ARB_MAX_OUTST = 4, and typedef fir_arb_id_t (logic [clog2(N_REQ)-1:0]).
- Sub-module fir_arb_id_fifo: synchronous FIFO with push/pop/full/empty, simultaneous push+pop, and rst_i/clear_i.

Test Plan:
1. Fairness: in_req = 3'b111 held, out_gnt = 1, responses returned 1 cycle after grant -> grants go to 0, 1, 2, 0, 1, 2; each in_r_valid bit fires exactly 1 cycle after its own grant.
2. Lock under stall:
   - Stimulus: req1 asserted, out_gnt = 0 for 3 cycles; req0 rises in cycle 2.
   - Response: out_add stays req1's address; req1 is granted in cycle 4; req0 is granted next.
3. Full: out_gnt = 1 and no responses for 4 grants -> out_req = 0 from the 5th cycle; one out_r_valid -> out_req returns to 1 on the next cycle, and that response routes to the first granter.
4. Out-of-band latency: grant order 2, 0, 2 with responses delayed 3, 1 and 0 extra cycles -> in_r_valid pulses hit 2, 0, 2 in order with the matching out_r_data (e.g. 0xA5A5_0002, 0xA5A5_0000, 0xA5A5_0012).
5. Spurious response: out_r_valid with an empty FIFO -> in_r_valid = 0 and err_o = 1 sticky; clear_i -> err_o = 0.
6. Reset mid-operation: 2 transactions outstanding, rst_i pulsed for 1 cycle -> busy_o = 0 and rr_ptr restarts at 0 (next grant goes to req0 when all requesters request); the late responses set err_o.
